// File: rtl/clock_set_controller.sv
// rtl/clock_set_controller.sv - button debounce and set-mode FSM for the HH:MM:SS clock
// Optional: define AUTOREPEAT_EN for INC hold-to-repeat.
module clock_set_controller #(
   parameter logic [15:0] DEBOUNCE_CYCLES = 16'd20000,
   parameter logic [3:0]  BLINK_TICKS     = 4'd1,
   parameter logic [5:0]  TIMEOUT_TICKS   = 6'd30,
   parameter logic [15:0] REPEAT_DELAY    = 16'd40000,
   parameter logic [15:0] REPEAT_PERIOD   = 16'd10000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       btn_mode,
   input  logic       btn_inc,
   input  logic       tick,
   input  logic [4:0] hour_in,
   input  logic [5:0] minute_in,
   output logic       run_en,
   output logic       load_en,
   output logic [4:0] hour_load,
   output logic [5:0] minute_load,
   output logic       sec_clear,
   output logic [1:0] blink_mask,
   output logic [1:0] mode_state
);

   typedef enum logic [1:0] {RUN = 2'b00, SET_HOUR = 2'b01, SET_MIN = 2'b10, COMMIT = 2'b11} state_t;

   state_t      state;
   logic [1:0]  sync1, sync2, db, db_q, press;
   logic [15:0] db_cnt [2];
   logic        mode_p, inc_p, inc_all;
   logic        phase;
   logic [3:0]  blink_cnt;
   logic [5:0]  tmo_cnt;

   // Bit 1 is MODE, bit 0 is INC throughout the conditioning path.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync1 <= '0;
         sync2 <= '0;
         db    <= '0;
         db_q  <= '0;
         press <= '0;
         for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
      end else begin
         sync1 <= {btn_mode, btn_inc};
         sync2 <= sync1;
         db_q  <= db;
         press <= db & ~db_q;
         for (int i = 0; i < 2; i++) begin
            if (sync2[i] == db[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] >= DEBOUNCE_CYCLES - 16'd1) begin
               db[i]     <= sync2[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + 16'd1;
            end
         end
      end
   end

   assign mode_p = press[1];
   assign inc_p  = press[0];

`ifdef AUTOREPEAT_EN
   logic        rep_on, rep_first, rep_p;
   logic [15:0] rep_cnt;
   state_t      rep_state;

   // rep_cnt holds the number of edges since arming/last pulse; state change or release stops it.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rep_on    <= 1'b0;
         rep_first <= 1'b0;
         rep_p     <= 1'b0;
         rep_cnt   <= '0;
         rep_state <= RUN;
      end else begin
         rep_p <= 1'b0;
         if (inc_p && (state == SET_HOUR || state == SET_MIN)) begin
            rep_on    <= 1'b1;
            rep_first <= 1'b1;
            rep_cnt   <= 16'd1;
            rep_state <= state;
         end else if (rep_on && db[0] && state == rep_state) begin
            if (rep_cnt >= (rep_first ? REPEAT_DELAY - 16'd1 : REPEAT_PERIOD)) begin
               rep_p     <= 1'b1;
               rep_first <= 1'b0;
               rep_cnt   <= 16'd1;
            end else begin
               rep_cnt <= rep_cnt + 16'd1;
            end
         end else begin
            rep_on <= 1'b0;
         end
      end
   end

   assign inc_all = inc_p | rep_p;
`else
   logic unused_repeat_cfg;
   assign unused_repeat_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD};
   assign inc_all = inc_p;
`endif

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state       <= RUN;
         run_en      <= 1'b1;
         load_en     <= 1'b0;
         sec_clear   <= 1'b0;
         blink_mask  <= 2'b00;
         hour_load   <= '0;
         minute_load <= '0;
         phase       <= 1'b0;
         blink_cnt   <= '0;
         tmo_cnt     <= '0;
      end else begin
         load_en   <= 1'b0;
         sec_clear <= 1'b0;
         case (state)
            RUN: begin
               if (mode_p) begin
                  state       <= SET_HOUR;
                  run_en      <= 1'b0;
                  hour_load   <= (hour_in > 5'd23) ? 5'd0 : hour_in;
                  minute_load <= (minute_in > 6'd59) ? 6'd0 : minute_in;
                  phase       <= 1'b0;
                  blink_cnt   <= '0;
                  tmo_cnt     <= '0;
                  blink_mask  <= 2'b00;
               end
            end
            SET_HOUR, SET_MIN: begin
               // MODE outranks INC; either press restarts timeout and blink phase.
               if (mode_p) begin
                  phase      <= 1'b0;
                  blink_cnt  <= '0;
                  tmo_cnt    <= '0;
                  blink_mask <= 2'b00;
                  if (state == SET_HOUR) begin
                     state <= SET_MIN;
                  end else begin
                     state     <= COMMIT;
                     load_en   <= 1'b1;
                     sec_clear <= 1'b1;
                  end
               end else if (inc_all) begin
                  phase      <= 1'b0;
                  blink_cnt  <= '0;
                  tmo_cnt    <= '0;
                  blink_mask <= 2'b00;
                  if (state == SET_HOUR)
                     hour_load <= (hour_load >= 5'd23) ? 5'd0 : hour_load + 5'd1;
                  else
                     minute_load <= (minute_load >= 6'd59) ? 6'd0 : minute_load + 6'd1;
               end else if (tick) begin
                  if (tmo_cnt >= TIMEOUT_TICKS - 6'd1) begin
                     state       <= RUN;
                     run_en      <= 1'b1;
                     blink_mask  <= 2'b00;
                     phase       <= 1'b0;
                     hour_load   <= '0;
                     minute_load <= '0;
                  end else begin
                     tmo_cnt <= tmo_cnt + 6'd1;
                     if (blink_cnt >= BLINK_TICKS - 4'd1) begin
                        blink_cnt  <= '0;
                        phase      <= ~phase;
                        blink_mask <= (state == SET_HOUR) ? {~phase, 1'b0} : {1'b0, ~phase};
                     end else begin
                        blink_cnt <= blink_cnt + 4'd1;
                     end
                  end
               end
            end
            COMMIT: begin
               state  <= RUN;
               run_en <= 1'b1;
            end
            default: state <= RUN;
         endcase
      end
   end

   assign mode_state = state;

endmodule

// File: tb/tb_clock_set_controller.sv
// tb/tb_clock_set_controller.sv - self-checking bench for clock_set_controller
module tb_clock_set_controller;

   localparam int DEB = 4;
   localparam int RDELAY = 8;
   localparam int RPERIOD = 4;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       btn_mode = 1'b0;
   logic       btn_inc = 1'b0;
   logic       tick = 1'b0;
   logic [4:0] hour_in = '0;
   logic [5:0] minute_in = '0;
   logic       run_en, load_en, sec_clear;
   logic [4:0] hour_load;
   logic [5:0] minute_load;
   logic [1:0] blink_mask, mode_state;

   clock_set_controller #(
      .DEBOUNCE_CYCLES(16'd4),
      .BLINK_TICKS(4'd1),
      .TIMEOUT_TICKS(6'd3),
      .REPEAT_DELAY(16'd8),
      .REPEAT_PERIOD(16'd4)
   ) dut (
      .clock(clock),
      .reset(reset),
      .btn_mode(btn_mode),
      .btn_inc(btn_inc),
      .tick(tick),
      .hour_in(hour_in),
      .minute_in(minute_in),
      .run_en(run_en),
      .load_en(load_en),
      .hour_load(hour_load),
      .minute_load(minute_load),
      .sec_clear(sec_clear),
      .blink_mask(blink_mask),
      .mode_state(mode_state)
   );

   always #5 clock = ~clock;

   int n_cmp = 0;
   int n_fail = 0;

   // Reference model: mode 0 RUN, 1 SET_HOUR, 2 SET_MIN; shadow hour/minute.
   int  ms = 0;
   int  mh = 0;
   int  mm = 0;
   bit  known = 1;
   int  exp_loads = 0;
   bit  commit_seen = 0;

   // Load-strobe monitor
   int          load_cnt = 0;
   logic [31:0] cap_h, cap_m, cap_sc, cap_ms, cap_run_during, cap_run_after;
   bit          after_pending = 0;

   always @(negedge clock) begin
      if (load_en === 1'b1) begin
         load_cnt++;
         cap_h = 32'(hour_load);
         cap_m = 32'(minute_load);
         cap_sc = 32'(sec_clear);
         cap_ms = 32'(mode_state);
         cap_run_during = 32'(run_en);
         after_pending = 1;
      end else if (after_pending) begin
         cap_run_after = 32'(run_en);
         after_pending = 0;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clock);
   endtask

   function automatic int clamp(input int v, input int top);
      return (v > top) ? 0 : v;
   endfunction

   task automatic model_mode();
      case (ms)
         0: begin
            ms = 1;
            mh = clamp(int'(hour_in), 23);
            mm = clamp(int'(minute_in), 59);
            known = 1;
         end
         1: ms = 2;
         default: begin
            ms = 0;
            exp_loads++;
            commit_seen = 1;
         end
      endcase
   endtask

   task automatic model_inc(input int count);
      if (ms == 1) mh = (mh + count) % 24;
      else if (ms == 2) mm = (mm + count) % 60;
   endtask

   task automatic check_all();
      check("mode_state", 32'(mode_state), ms);
      check("run_en", 32'(run_en), (ms == 0) ? 1 : 0);
      check("blink_mask", 32'(blink_mask), 0);
      if (known) begin
         check("hour_load", 32'(hour_load), mh);
         check("minute_load", 32'(minute_load), mm);
      end
      check("load_count", load_cnt, exp_loads);
      if (commit_seen) begin
         commit_seen = 0;
         check("commit_hour", cap_h, mh);
         check("commit_minute", cap_m, mm);
         check("commit_sec_clear", cap_sc, 1);
         check("commit_state", cap_ms, 3);
         check("commit_run_during", cap_run_during, 0);
         check("commit_run_after", cap_run_after, 1);
      end
   endtask

   task automatic press(input bit m, input bit i);
      @(negedge clock);
      btn_mode = m;
      btn_inc = i;
      step(3 * DEB);
      btn_mode = 0;
      btn_inc = 0;
      step(3 * DEB + 2);
      if (m) model_mode();
      else if (i) model_inc(1);
      check_all();
   endtask

   task automatic pulse_tick();
      @(negedge clock);
      tick = 1;
      @(negedge clock);
      tick = 0;
      step(2);
   endtask

   initial begin
      int loads_before;
      int hold;
      int reps;

      // Reset state
      step(3);
      check("rst_mode_state", 32'(mode_state), 0);
      check("rst_run_en", 32'(run_en), 1);
      check("rst_load_en", 32'(load_en), 0);
      check("rst_sec_clear", 32'(sec_clear), 0);
      check("rst_blink", 32'(blink_mask), 0);
      check("rst_hour_load", 32'(hour_load), 0);
      check("rst_minute_load", 32'(minute_load), 0);
      reset = 1;
      step(2);

      // Debounce: a 3-cycle glitch is rejected, a 6-cycle assertion is accepted
      hour_in = 5'd13;
      minute_in = 6'd45;
      btn_mode = 1;
      step(3);
      btn_mode = 0;
      step(10);
      check("glitch_rejected", 32'(mode_state), 0);
      btn_mode = 1;
      step(6);
      btn_mode = 0;
      step(14);
      model_mode();
      check_all();
      press(1, 0);
      press(1, 0);

      // Wrap sequence from 22:58
      hour_in = 5'd22;
      minute_in = 6'd58;
      press(1, 0);
      repeat (3) press(0, 1);
      press(1, 0);
      repeat (2) press(0, 1);
      press(1, 0);
      check("wrap_committed_hour", cap_h, 1);
      check("wrap_committed_minute", cap_m, 0);

      // Simultaneous MODE + INC: MODE wins
      hour_in = 5'd7;
      minute_in = 6'd30;
      press(1, 0);
      press(1, 1);
      press(1, 0);

      // Blink and timeout in SET_MIN
      press(1, 0);
      press(1, 0);
      loads_before = load_cnt;
      pulse_tick();
      check("blink_min_t1", 32'(blink_mask), 1);
      check("state_min_t1", 32'(mode_state), 2);
      pulse_tick();
      check("blink_min_t2", 32'(blink_mask), 0);
      pulse_tick();
      check("timeout_state", 32'(mode_state), 0);
      check("timeout_blink", 32'(blink_mask), 0);
      check("timeout_run_en", 32'(run_en), 1);
      check("timeout_no_load", load_cnt, loads_before);
      ms = 0;
      known = 0;

      // Blink in SET_HOUR; INC restarts phase and timeout
      hour_in = 5'd3;
      minute_in = 6'd4;
      press(1, 0);
      pulse_tick();
      check("blink_hour_t1", 32'(blink_mask), 2);
      press(0, 1);
      pulse_tick();
      check("blink_hour_t2", 32'(blink_mask), 2);
      pulse_tick();
      check("blink_hour_t3", 32'(blink_mask), 0);
      check("no_timeout_yet", 32'(mode_state), 1);
      pulse_tick();
      check("timeout_hour_state", 32'(mode_state), 0);
      ms = 0;
      known = 0;

      // Hold INC in SET_MIN from minute 10 (debounced level high for 'hold' cycles)
      hour_in = 5'd9;
      minute_in = 6'd10;
      press(1, 0);
      press(1, 0);
      hold = 20;
      @(negedge clock);
      btn_inc = 1;
      step(hold);
      btn_inc = 0;
      step(3 * DEB + 4);
`ifdef AUTOREPEAT_EN
      reps = (hold > RDELAY) ? ((hold - RDELAY - 1) / RPERIOD + 1) : 0;
`else
      reps = 0;
`endif
      model_inc(1 + reps);
      check("hold_minute", 32'(minute_load), mm);
      press(1, 0);

      // Asynchronous reset in SET_MIN with shadow minute 17
      hour_in = 5'd5;
      minute_in = 6'd17;
      press(1, 0);
      press(1, 0);
      loads_before = load_cnt;
      @(negedge clock);
      #2 reset = 0;
      #1;
      check("arst_state", 32'(mode_state), 0);
      check("arst_run_en", 32'(run_en), 1);
      check("arst_hour", 32'(hour_load), 0);
      check("arst_minute", 32'(minute_load), 0);
      step(3);
      reset = 1;
      step(5);
      check("arst_no_load", load_cnt, loads_before);
      check("arst_state_after", 32'(mode_state), 0);
      ms = 0;
      mh = 0;
      mm = 0;
      known = 1;

      // Randomised button traffic including out-of-range capture values
      for (int k = 0; k < 24; k++) begin
         int r;
         r = int'($urandom_range(0, 3));
         hour_in = 5'($urandom_range(0, 31));
         minute_in = 6'($urandom_range(0, 63));
         case (r)
            0: press(1, 0);
            1: press(0, 1);
            2: press(1, 1);
            default: press(0, 1);
         endcase
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
